// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer: trap / branch / deferred-branch / return-stack / sequential.
// Optional return-address stack is enabled with the PC_SEQUENCER_RAS_EN macro.
module pc_sequencer #(
    parameter int unsigned      PCLEN        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [PCLEN-1:0] RESET_VECTOR = '0,
    parameter logic [PCLEN-1:0] TRAP_VECTOR  = PCLEN'(32'h80),
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             trap,
    input  logic             branch_taken,
    input  logic [PCLEN-1:0] branch_target,
    input  logic             call,
    input  logic             ret,
    output logic [PCLEN-1:0] pc,
    output logic [PCLEN-1:0] pc_last,
    output logic [PCLEN-1:0] pc_plus,
    output logic             fetch_valid,
    output logic             misalign,
    output logic             pend_valid,
    output logic             ras_empty
);

    localparam logic [PCLEN-1:0] ALIGN_MASK = ~PCLEN'(STEP - 1);

    logic [PCLEN-1:0] tgt_aligned;
    logic             tgt_mis;
    logic [PCLEN-1:0] pend_tgt;
    logic             pend_call;
    logic             ras_pop;
    logic [PCLEN-1:0] ras_top;

    assign tgt_aligned = branch_target & ALIGN_MASK;
    assign tgt_mis     = |(branch_target & ~ALIGN_MASK);
    assign pc_plus     = pc + PCLEN'(STEP);

`ifdef PC_SEQUENCER_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PCLEN-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_wp;
    logic [PW:0]      ras_cnt;
    logic [PW-1:0]    ras_top_idx;
    logic             ras_push;

    assign ras_top_idx = ras_wp - PW'(1);
    assign ras_top     = ras_mem[ras_top_idx];
    assign ras_empty   = (ras_cnt == '0);

    // Stack activity mirrors the next-PC priority: only unstalled, non-trap cycles touch it.
    always_comb begin
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!rst && !trap && !stall) begin
            if (branch_taken)
                ras_push = call;
            else if (pend_valid)
                ras_push = pend_call;
            else
                ras_pop = ret && !ras_empty;
        end
    end

    // Circular buffer: pushing when full simply overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ras_wp  <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_mem[ras_wp] <= pc_plus;
            ras_wp          <= ras_wp + PW'(1);
            if (ras_cnt != (PW+1)'(RAS_DEPTH))
                ras_cnt <= ras_cnt + (PW+1)'(1);
        end else if (ras_pop) begin
            ras_wp  <= ras_wp - PW'(1);
            ras_cnt <= ras_cnt - (PW+1)'(1);
        end
    end
`else
    logic unused_ras;

    assign ras_pop    = 1'b0;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = ^{ret, pend_call};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_VECTOR;
            pc_last     <= RESET_VECTOR;
            fetch_valid <= 1'b0;
            misalign    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_tgt    <= '0;
            pend_call   <= 1'b0;
        end else begin
            fetch_valid <= 1'b1;
            misalign    <= 1'b0;
            if (trap) begin
                pc_last    <= pc;
                pc         <= TRAP_VECTOR;
                pend_valid <= 1'b0;
                pend_call  <= 1'b0;
            end else if (stall) begin
                // Deferred redirect: the newest branch seen during the stall wins.
                if (branch_taken) begin
                    pend_valid <= 1'b1;
                    pend_tgt   <= tgt_aligned;
                    pend_call  <= call;
                    misalign   <= tgt_mis;
                end
            end else if (branch_taken) begin
                pc_last    <= pc;
                pc         <= tgt_aligned;
                pend_valid <= 1'b0;
                pend_call  <= 1'b0;
                misalign   <= tgt_mis;
            end else if (pend_valid) begin
                pc_last    <= pc;
                pc         <= pend_tgt;
                pend_valid <= 1'b0;
                pend_call  <= 1'b0;
            end else if (ras_pop) begin
                pc_last <= pc;
                pc      <= ras_top;
            end else begin
                pc_last <= pc;
                pc      <= pc_plus;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a 32-bit and an 8-bit instance share stimulus and are checked against a queue-based model.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, trap = 1'b0, bt = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] tgt = '0;

    logic [31:0] d0_pc, d0_last, d0_plus;
    logic        d0_fv, d0_mis, d0_pv, d0_re;
    logic [7:0]  d1_pc, d1_last, d1_plus;
    logic        d1_fv, d1_mis, d1_pv, d1_re;

    pc_sequencer #(.PCLEN(32), .STEP(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h80), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .branch_taken(bt), .branch_target(tgt),
        .call(call), .ret(ret), .pc(d0_pc), .pc_last(d0_last), .pc_plus(d0_plus),
        .fetch_valid(d0_fv), .misalign(d0_mis), .pend_valid(d0_pv), .ras_empty(d0_re));

    pc_sequencer #(.PCLEN(8), .STEP(4), .RESET_VECTOR(8'h0), .TRAP_VECTOR(8'h80), .RAS_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .trap(trap), .branch_taken(bt), .branch_target(tgt[7:0]),
        .call(call), .ret(ret), .pc(d1_pc), .pc_last(d1_last), .pc_plus(d1_plus),
        .fetch_valid(d1_fv), .misalign(d1_mis), .pend_valid(d1_pv), .ras_empty(d1_re));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = 32-bit instance, index 1 = 8-bit instance.
    logic [31:0] mask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_pc [2], m_last [2], m_ptgt [2];
    bit          m_fv [2], m_mis [2], m_pv [2], m_pcall [2];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic qpush(input int k, input logic [31:0] v);
        logic [31:0] drop;
        if (k == 0) begin
            q0.push_back(v);
            if (q0.size() > DEPTH) drop = q0.pop_front();
        end else begin
            q1.push_back(v);
            if (q1.size() > DEPTH) drop = q1.pop_front();
        end
    endtask

    task automatic qpop(input int k, output logic [31:0] v);
        if (k == 0) v = q0.pop_back();
        else        v = q1.pop_back();
    endtask

    task automatic model_step(input int k);
        logic [31:0] plus, atgt, v;
        plus = (m_pc[k] + 32'd4) & mask[k];
        atgt = tgt & mask[k] & ~32'd3;
        if (rst) begin
            m_pc[k] = 0; m_last[k] = 0; m_fv[k] = 0; m_mis[k] = 0;
            m_pv[k] = 0; m_ptgt[k] = 0; m_pcall[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            m_fv[k]  = 1;
            m_mis[k] = 0;
            if (trap) begin
                m_last[k] = m_pc[k]; m_pc[k] = 32'h80; m_pv[k] = 0; m_pcall[k] = 0;
            end else if (stall) begin
                if (bt) begin
                    m_pv[k] = 1; m_ptgt[k] = atgt; m_pcall[k] = call; m_mis[k] = |tgt[1:0];
                end
            end else if (bt) begin
                if (RAS && call) qpush(k, plus);
                m_last[k] = m_pc[k]; m_pc[k] = atgt; m_pv[k] = 0; m_pcall[k] = 0; m_mis[k] = |tgt[1:0];
            end else if (m_pv[k]) begin
                if (RAS && m_pcall[k]) qpush(k, plus);
                m_last[k] = m_pc[k]; m_pc[k] = m_ptgt[k]; m_pv[k] = 0; m_pcall[k] = 0;
            end else if (RAS && ret && qsize(k) > 0) begin
                qpop(k, v);
                m_last[k] = m_pc[k]; m_pc[k] = v;
            end else begin
                m_last[k] = m_pc[k]; m_pc[k] = plus;
            end
        end
    endtask

    function automatic logic m_re(input int k);
        return RAS ? (qsize(k) == 0) : 1'b1;
    endfunction

    // Every-cycle comparison against the model, 1 time unit after each edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            chk("pc32",      d0_pc,   m_pc[0]);
            chk("last32",    d0_last, m_last[0]);
            chk("plus32",    d0_plus, (m_pc[0] + 32'd4) & mask[0]);
            chk("fv32",      {31'd0, d0_fv},  {31'd0, m_fv[0]});
            chk("mis32",     {31'd0, d0_mis}, {31'd0, m_mis[0]});
            chk("pv32",      {31'd0, d0_pv},  {31'd0, m_pv[0]});
            chk("rempty32",  {31'd0, d0_re},  {31'd0, m_re(0)});
            chk("pc8",       {24'd0, d1_pc},   m_pc[1]);
            chk("last8",     {24'd0, d1_last}, m_last[1]);
            chk("plus8",     {24'd0, d1_plus}, (m_pc[1] + 32'd4) & mask[1]);
            chk("fv8",       {31'd0, d1_fv},  {31'd0, m_fv[1]});
            chk("mis8",      {31'd0, d1_mis}, {31'd0, m_mis[1]});
            chk("pv8",       {31'd0, d1_pv},  {31'd0, m_pv[1]});
            chk("rempty8",   {31'd0, d1_re},  {31'd0, m_re(1)});
        end
    end

    task automatic step(input bit r, input bit s, input bit tr, input bit b,
                        input bit c, input bit rt, input logic [31:0] t);
        @(negedge clk);
        rst = r; stall = s; trap = tr; bt = b; call = c; ret = rt; tgt = t;
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pc", d0_pc, 32'h0);
        chk("rst_last", d0_last, 32'h0);
        chk("rst_fv", {31'd0, d0_fv}, 32'd0);
        chk("rst_re", {31'd0, d0_re}, 32'd1);

        step(0,0,0,0,0,0, 0); chk("free1_pc", d0_pc, 32'h4); chk("free1_last", d0_last, 32'h0);
        chk("free1_fv", {31'd0, d0_fv}, 32'd1);
        step(0,0,0,0,0,0, 0); chk("free2_pc", d0_pc, 32'h8); chk("free2_last", d0_last, 32'h4);
        step(0,0,0,0,0,0, 0); chk("free3_pc", d0_pc, 32'hC); chk("free3_last", d0_last, 32'h8);
        step(0,0,0,0,0,0, 0); chk("free4_pc", d0_pc, 32'h10);

        step(0,1,0,1,0,0, 32'h200); chk("stall1_pc", d0_pc, 32'h10); chk("stall1_pv", {31'd0, d0_pv}, 32'd1);
        step(0,1,0,0,0,0, 0);       chk("stall2_pc", d0_pc, 32'h10); chk("stall2_pv", {31'd0, d0_pv}, 32'd1);
        step(0,0,0,0,0,0, 0);       chk("defer_pc", d0_pc, 32'h200); chk("defer_pv", {31'd0, d0_pv}, 32'd0);
        chk("defer_last", d0_last, 32'h10);

        step(0,1,0,1,0,0, 32'h200); chk("pend_pv", {31'd0, d0_pv}, 32'd1);
        step(0,1,1,0,0,0, 0);       chk("trap_pc", d0_pc, 32'h80); chk("trap_pv", {31'd0, d0_pv}, 32'd0);
        step(0,0,0,0,0,0, 0);       chk("trap_next", d0_pc, 32'h84);

        step(0,0,0,1,0,0, 32'h103); chk("mis_pc", d0_pc, 32'h100); chk("mis_on", {31'd0, d0_mis}, 32'd1);
        step(0,0,0,0,0,0, 0);       chk("mis_off", {31'd0, d0_mis}, 32'd0);

        step(0,0,0,1,0,0, 32'hFC);  chk("w8_pre", {24'd0, d1_pc}, 32'hFC);
        step(0,0,0,0,0,0, 0);       chk("w8_wrap", {24'd0, d1_pc}, 32'h00); chk("w32_nowrap", d0_pc, 32'h100);

        step(0,0,0,1,0,0, 32'h10);
        step(0,0,0,1,1,0, 32'h40);
        step(0,0,0,1,1,0, 32'h80);
        step(0,0,0,1,1,0, 32'h300); chk("call_pc", d0_pc, 32'h300);
        step(0,0,0,0,0,1, 0);       chk("ret1", d0_pc, RAS ? 32'h84 : 32'h304);
        step(0,0,0,0,0,1, 0);       chk("ret2", d0_pc, RAS ? 32'h44 : 32'h308);
        chk("ret2_re", {31'd0, d0_re}, 32'd1);
        step(0,0,0,0,0,1, 0);       chk("ret3", d0_pc, RAS ? 32'h48 : 32'h30C);
        chk("ret3_re", {31'd0, d0_re}, 32'd1);

        step(0,0,0,1,1,0, 32'h500);
        step(0,1,0,1,0,0, 32'h600); chk("prerst_pv", {31'd0, d0_pv}, 32'd1);
        chk("prerst_re", {31'd0, d0_re}, RAS ? 32'd0 : 32'd1);
        step(1,1,0,0,0,0, 0);       chk("rst2_pc", d0_pc, 32'h0); chk("rst2_pv", {31'd0, d0_pv}, 32'd0);
        chk("rst2_re", {31'd0, d0_re}, 32'd1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(99) < 1);
            stall = ($urandom_range(99) < 25);
            trap  = ($urandom_range(99) < 3);
            bt    = ($urandom_range(99) < 20);
            call  = ($urandom_range(1) == 1);
            ret   = ($urandom_range(99) < 20);
            tgt   = $urandom;
            if ($urandom_range(1) == 1) tgt[1:0] = 2'b00;
        end
        @(negedge clk);
        rst = 0; stall = 0; trap = 0; bt = 0; call = 0; ret = 0;
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
